// File: rtl/button_conditioner_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Replaces the old button_cond_defs.vh header.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } bc_state_t;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_REPEAT_EN       = 1;
    localparam int unsigned DEF_REPEAT_DELAY    = 64;
    localparam int unsigned DEF_REPEAT_PERIOD   = 16;
    localparam int unsigned DEF_CNT_W           = 8;

endpackage

// File: rtl/button_conditioner_if.sv
// Button-side signal bundle: raw input and enable in, conditioned outputs back.
interface button_conditioner_if;

    logic btn_raw;
    logic enable;
    logic btn_pulse;
    logic btn_level;
    logic repeat_active;

    modport master (
        output btn_raw, enable,
        input  btn_pulse, btn_level, repeat_active
    );

    modport slave (
        input  btn_raw, enable,
        output btn_pulse, btn_level, repeat_active
    );

endinterface

// File: rtl/button_conditioner_debounce_filter.sv
// Synchroniser plus debounce counter: turns the raw asynchronous button into
// a clean level that only changes after DEBOUNCE_CYCLES stable synced samples.
module debounce_filter
    import button_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    output logic o_btn_level
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   w_sync;

    assign w_sync      = r_sync[SYNC_STAGES-1];
    assign o_btn_level = r_level;

    // Any sample matching the current level discards accumulated credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_raw};
            if (w_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= w_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: debounced level, one-cycle press pulse and
// optional hold-to-repeat pulses for the LED colour stepper.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_EN       = DEF_REPEAT_EN,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int unsigned CNT_W           = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    button_conditioner_if.slave  bus
);

    logic             w_level;
    logic             r_level_d;
    bc_state_t        r_state;
    bc_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_rpt_cnt;
    logic [CNT_W-1:0] w_rpt_cnt_nxt;
    logic             r_pulse;
    logic             w_pulse_nxt;

    debounce_filter #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk         (clk),
        .rst         (rst),
        .i_btn_raw   (bus.btn_raw),
        .o_btn_level (w_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_rpt_cnt <= '0;
            r_pulse   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rpt_cnt <= w_rpt_cnt_nxt;
            r_pulse   <= w_pulse_nxt;
            r_level_d <= w_level;
        end
    end

    // Release is tested before the repeat tick so a release always wins.
    always_comb begin
        w_state_nxt   = r_state;
        w_rpt_cnt_nxt = r_rpt_cnt;
        w_pulse_nxt   = 1'b0;
        if (!bus.enable) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_level && !r_level_d) begin
                        w_pulse_nxt   = 1'b1;
                        w_state_nxt   = HOLD;
                        w_rpt_cnt_nxt = '0;
                    end
                end
                HOLD: begin
                    if (!w_level) begin
                        w_state_nxt = IDLE;
                    end else if (REPEAT_EN != 0) begin
                        if (r_rpt_cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                            w_pulse_nxt   = 1'b1;
                            w_rpt_cnt_nxt = '0;
                            w_state_nxt   = REPEAT;
                        end else begin
                            w_rpt_cnt_nxt = r_rpt_cnt + CNT_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (!w_level) begin
                        w_state_nxt = IDLE;
                    end else if (r_rpt_cnt == CNT_W'(REPEAT_PERIOD - 1)) begin
                        w_pulse_nxt   = 1'b1;
                        w_rpt_cnt_nxt = '0;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + CNT_W'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign bus.btn_pulse     = r_pulse;
    assign bus.btn_level     = w_level;
    assign bus.repeat_active = (r_state == REPEAT);

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (repeat off / on) driven by the
// same button, checked against a window/time-based reference model.
module tb_button_conditioner;

    localparam int S  = 2;
    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clk;
    logic rst;
    logic raw;
    logic en;
    logic [1:0] colour;

    int checks;
    int errs;

    button_conditioner_if bif0 ();
    button_conditioner_if bif1 ();

    assign bif0.btn_raw = raw;
    assign bif0.enable  = en;
    assign bif1.btn_raw = raw;
    assign bif1.enable  = en;

    button_conditioner #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(4)
    ) dut0 (.clk(clk), .rst(rst), .bus(bif0));

    button_conditioner #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .CNT_W(4)
    ) dut1 (.clk(clk), .rst(rst), .bus(bif1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the LED colour stepper fed by the repeat-enabled instance.
    always_ff @(posedge clk) begin
        if (rst) colour <= '0;
        else if (bif1.btn_pulse) colour <= colour + 2'd1;
    end

    // Reference model: level flips when the last DB synced samples all differ
    // from it; pulses are scheduled by elapsed time since the accepted press.
    bit Lm, Lp;
    bit act [2];
    int t0  [2];
    bit ep  [2];
    bit era [2];
    int n;
    bit hist [$];
    bit dwin [$];

    always @(posedge clk) begin
        bit d;
        bit flip;
        int k;
        if (rst) begin
            hist.delete();
            dwin.delete();
            Lm = 0; Lp = 0;
            for (int c = 0; c < 2; c++) begin
                act[c] = 0; ep[c] = 0; era[c] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (!en || !Lm) begin
                    act[c] = 0; ep[c] = 0; era[c] = 0;
                end else if (!act[c] && !Lp) begin
                    act[c] = 1; t0[c] = n; ep[c] = 1; era[c] = 0;
                end else if (act[c]) begin
                    k = n - t0[c];
                    era[c] = (c == 1) && (k >= RD);
                    ep[c]  = era[c] && (((k - RD) % RP) == 0);
                end else begin
                    ep[c] = 0; era[c] = 0;
                end
            end
            Lp = Lm;
            d = (hist.size() >= S) ? hist[hist.size() - S] : 1'b0;
            dwin.push_back(d);
            if (dwin.size() > DB) void'(dwin.pop_front());
            if (dwin.size() == DB) begin
                flip = 1;
                foreach (dwin[i]) if (dwin[i] == Lm) flip = 0;
                if (flip) Lm = !Lm;
            end
            hist.push_back(raw);
            if (hist.size() > S) void'(hist.pop_front());
        end
        n++;
    end

    function automatic logic [5:0] got6();
        return {bif0.btn_pulse, bif0.btn_level, bif0.repeat_active,
                bif1.btn_pulse, bif1.btn_level, bif1.repeat_active};
    endfunction

    function automatic logic [5:0] exp6();
        return {ep[0], Lm, era[0], ep[1], Lm, era[1]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; raw = 0; en = 1;
        cyc(); cyc();
        rst = 0;
        cyc(); cyc();
    endtask

    task automatic test_reset();
        int pe;
        rst = 1; raw = 1; en = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (got6() !== 6'b0) begin
                errs++;
                $display("FAIL reset_outputs cyc=%0d got=%b exp=000000", i, got6());
            end
        end
        // Button still held when reset drops: counts as a fresh press.
        rst = 0;
        pe = -1;
        for (int e = 1; e <= 12; e++) begin
            cyc();
            if (bif0.btn_pulse && pe < 0) pe = e;
            checks++;
            if (got6() !== exp6()) begin
                errs++;
                $display("FAIL reset_release_model edge=%0d got=%b exp=%b", e, got6(), exp6());
            end
        end
        checks++;
        if (pe != 7) begin
            errs++;
            $display("FAIL reset_release_latency got=%0d exp=7", pe);
        end
    endtask

    task automatic test_single_press();
        int pe, le, np;
        do_reset();
        pe = -1; le = -1; np = 0;
        raw = 1;
        for (int e = 1; e <= 30; e++) begin
            cyc();
            if (bif0.btn_pulse) begin np++; if (pe < 0) pe = e; end
            if (bif0.btn_level && le < 0) le = e;
            checks++;
            if (got6() !== exp6()) begin
                errs++;
                $display("FAIL single_model edge=%0d got=%b exp=%b", e, got6(), exp6());
            end
        end
        checks++;
        if (pe != 7 || np != 1) begin
            errs++;
            $display("FAIL single_pulse got_edge=%0d got_count=%0d exp_edge=7 exp_count=1", pe, np);
        end
        checks++;
        if (le != 6) begin
            errs++;
            $display("FAIL single_level got=%0d exp=6", le);
        end
    endtask

    task automatic test_bounce();
        int pe, nb;
        do_reset();
        pe = -1; nb = 0;
        for (int e = 1; e <= 30; e++) begin
            raw = (e - 1 >= 12) ? 1'b1 : (((e - 1) % 4) < 2);
            cyc();
            if (bif0.btn_pulse || bif1.btn_pulse) begin
                if (e < 13) nb++;
                else if (pe < 0) pe = e;
            end
            checks++;
            if (got6() !== exp6()) begin
                errs++;
                $display("FAIL bounce_model edge=%0d got=%b exp=%b", e, got6(), exp6());
            end
        end
        checks++;
        if (nb != 0 || pe != 12 + 7) begin
            errs++;
            $display("FAIL bounce_pulse got_bounce=%0d got_edge=%0d exp_bounce=0 exp_edge=19", nb, pe);
        end
    endtask

    task automatic test_repeat();
        int got [$];
        int expq [$];
        int ra;
        do_reset();
        ra = -1;
        raw = 1;
        for (int e = 1; e <= 30; e++) begin
            cyc();
            if (bif1.btn_pulse) got.push_back(e);
            if (bif1.repeat_active && ra < 0) ra = e;
            checks++;
            if (got6() !== exp6()) begin
                errs++;
                $display("FAIL repeat_model edge=%0d got=%b exp=%b", e, got6(), exp6());
            end
        end
        expq.push_back(7);
        for (int t = 7 + RD; t <= 30; t += RP) expq.push_back(t);
        checks++;
        if (got != expq) begin
            errs++;
            $display("FAIL repeat_schedule got=%p exp=%p", got, expq);
        end
        checks++;
        if (ra != 15) begin
            errs++;
            $display("FAIL repeat_active_start got=%0d exp=15", ra);
        end
    endtask

    task automatic test_release_enable();
        int np;
        // Level falls three cycles after HOLD is entered.
        do_reset();
        np = 0;
        for (int e = 1; e <= 30; e++) begin
            raw = (e <= 4);
            cyc();
            if (e > 7 && bif1.btn_pulse) np++;
            checks++;
            if (got6() !== exp6()) begin
                errs++;
                $display("FAIL release_model edge=%0d got=%b exp=%b", e, got6(), exp6());
            end
        end
        checks++;
        if (np != 0) begin
            errs++;
            $display("FAIL release_no_pulse got=%0d exp=0", np);
        end
        // Enable dropped while repeating: next cycle is quiet and idle.
        do_reset();
        raw = 1;
        for (int e = 1; e <= 17; e++) cyc();
        en = 0;
        np = 0;
        for (int e = 18; e <= 26; e++) begin
            cyc();
            if (bif1.btn_pulse || bif1.repeat_active) np++;
            checks++;
            if (got6() !== exp6()) begin
                errs++;
                $display("FAIL enable_drop_model edge=%0d got=%b exp=%b", e, got6(), exp6());
            end
        end
        checks++;
        if (np != 0) begin
            errs++;
            $display("FAIL enable_drop_quiet got=%0d exp=0", np);
        end
        // Re-enable while still held: the old press is not replayed.
        en = 1;
        np = 0;
        for (int e = 0; e < 10; e++) begin
            cyc();
            if (bif0.btn_pulse || bif1.btn_pulse) np++;
        end
        checks++;
        if (np != 0) begin
            errs++;
            $display("FAIL enable_restore_no_pulse got=%0d exp=0", np);
        end
    endtask

    task automatic test_random();
        int run;
        do_reset();
        run = 0;
        for (int i = 0; i < 1500; i++) begin
            if (run == 0) begin
                raw = $urandom_range(0, 1);
                run = $urandom_range(1, 20);
            end
            run--;
            if ($urandom_range(0, 79) == 0) en = ~en;
            rst = ($urandom_range(0, 399) == 0);
            cyc();
            checks++;
            if (got6() !== exp6()) begin
                errs++;
                $display("FAIL random_model i=%0d got=%b exp=%b", i, got6(), exp6());
            end
        end
        rst = 0; en = 1;
    endtask

    task automatic test_led_chain();
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int e = 0; e < 18; e++) begin
                raw = (e < 6);
                cyc();
                checks++;
                if (got6() !== exp6()) begin
                    errs++;
                    $display("FAIL led_model press=%0d e=%0d got=%b exp=%b", p, e, got6(), exp6());
                end
            end
        end
        cyc();
        checks++;
        if (colour !== 2'd3) begin
            errs++;
            $display("FAIL led_colour got=%0d exp=3", colour);
        end
    endtask

    initial begin
        checks = 0; errs = 0; n = 0;
        rst = 1; raw = 0; en = 1;
        test_reset();
        test_single_press();
        test_bounce();
        test_repeat();
        test_release_enable();
        test_random();
        test_led_chain();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
